// File: rtl/std_stream_serializer_if.sv
// rtl/std_stream_serializer_if.sv - valid/ready/payload stream interface shared by the flow stages
interface std_stream_intf #(
    parameter int WIDTH = 8
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] payload;

    modport in  (input valid, input payload, output ready);
    modport out (output valid, output payload, input ready);
endinterface

// File: rtl/std_stream_serializer.sv
// rtl/std_stream_serializer.sv - splits one wide stream word into COUNT narrow beats with last
module std_stream_serializer #(
    parameter type T_OUT     = logic [7:0],
    parameter int  COUNT     = 4,
    parameter bit  LSB_FIRST = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    std_stream_intf.in     stream_in,
    std_stream_intf.out    stream_out,
    output logic           last
);
    localparam int W      = $bits(T_OUT);
    localparam int WORD_W = COUNT * W;
    localparam int IW     = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(COUNT - 1);

    generate
        if (COUNT < 1) begin : g_bad_count
            $error("std_stream_serializer: COUNT must be at least 1");
        end
        if ($bits(stream_out.payload) != W) begin : g_bad_out_width
            $error("std_stream_serializer: stream_out payload width must equal T_OUT width");
        end
        if ($bits(stream_in.payload) != WORD_W) begin : g_bad_in_width
            $error("std_stream_serializer: stream_in payload width must equal COUNT*T_OUT width");
        end
    endgenerate

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [IW-1:0]       index;
    logic [IW-1:0]       index_nxt;
    logic [IW-1:0]       slot;
    logic [WORD_W-1:0]   word;
    logic                busy;
    logic                at_last;
    logic                in_xfer;
    logic                out_xfer;

    assign busy    = (state == S_BUSY);
    assign at_last = (index == LAST_IDX);

    // Ready looks through to the output so a new word can load on the edge the last beat leaves.
    assign stream_in.ready  = !busy || (stream_out.ready && at_last);
    assign stream_out.valid = busy;
    assign last             = busy && at_last;

    assign in_xfer  = stream_in.valid && stream_in.ready;
    assign out_xfer = busy && stream_out.ready;

    assign slot               = LSB_FIRST ? index : (LAST_IDX - index);
    assign stream_out.payload = word[int'(slot) * W +: W];

    always_comb begin
        state_nxt = state;
        index_nxt = index;
        if (out_xfer) begin
            if (at_last) begin
                index_nxt = '0;
                state_nxt = S_IDLE;
            end else begin
                index_nxt = index + 1'b1;
            end
        end
        // A fresh word overrides the end-of-word clear.
        if (in_xfer) begin
            state_nxt = S_BUSY;
            index_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            index <= '0;
        end else begin
            state <= state_nxt;
            index <= index_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (in_xfer) begin
            word <= stream_in.payload;
        end
    end
endmodule

// File: tb/tb_std_stream_serializer.sv
// tb/tb_std_stream_serializer.sv - directed vector bench for std_stream_serializer
module tb_std_stream_serializer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    std_stream_intf #(.WIDTH(32)) a_in ();
    std_stream_intf #(.WIDTH(8))  a_out ();
    std_stream_intf #(.WIDTH(32)) b_in ();
    std_stream_intf #(.WIDTH(8))  b_out ();
    std_stream_intf #(.WIDTH(16)) c_in ();
    std_stream_intf #(.WIDTH(16)) c_out ();
    logic a_last, b_last, c_last;

    std_stream_serializer #(.T_OUT(logic [7:0]), .COUNT(4), .LSB_FIRST(1'b1)) u_a (
        .clk(clk), .rst(rst), .stream_in(a_in), .stream_out(a_out), .last(a_last));
    std_stream_serializer #(.T_OUT(logic [7:0]), .COUNT(4), .LSB_FIRST(1'b0)) u_b (
        .clk(clk), .rst(rst), .stream_in(b_in), .stream_out(b_out), .last(b_last));
    std_stream_serializer #(.T_OUT(logic [15:0]), .COUNT(1), .LSB_FIRST(1'b1)) u_c (
        .clk(clk), .rst(rst), .stream_in(c_in), .stream_out(c_out), .last(c_last));

    typedef struct {
        logic        rst;
        logic        chk;
        logic        iv;
        logic [31:0] id;
        logic        ordy;
        logic        ov;
        logic [7:0]  od;
        logic        last;
        logic        irdy;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(logic r, logic c, logic iv, logic [31:0] id, logic ordy,
                                logic ov, logic [7:0] od, logic l, logic irdy);
        vec_t v;
        v.rst = r; v.chk = c; v.iv = iv; v.id = id; v.ordy = ordy;
        v.ov = ov; v.od = od; v.last = l; v.irdy = irdy;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        a_in.valid = 1'b0; a_in.payload = '0; a_out.ready = 1'b1;
        b_in.valid = 1'b0; b_in.payload = '0; b_out.ready = 1'b1;
        c_in.valid = 1'b0; c_in.payload = '0; c_out.ready = 1'b1;

        //               rst  chk  iv   payload       ordy ov   od     last irdy
        vecs.push_back(mk(1, 0, 0, 32'h0,        1, 0, 8'h00, 0, 1));
        // single word, ready high
        vecs.push_back(mk(0, 1, 1, 32'hDDCCBBAA, 1, 0, 8'h00, 0, 1));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 1, 8'hAA, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 1, 8'hBB, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 1, 8'hCC, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 1, 8'hDD, 1, 1));
        // back-to-back words, no gap
        vecs.push_back(mk(0, 1, 1, 32'h03020100, 1, 0, 8'h00, 0, 1));
        vecs.push_back(mk(0, 1, 1, 32'h07060504, 1, 1, 8'h00, 0, 0));
        vecs.push_back(mk(0, 1, 1, 32'h07060504, 1, 1, 8'h01, 0, 0));
        vecs.push_back(mk(0, 1, 1, 32'h07060504, 1, 1, 8'h02, 0, 0));
        vecs.push_back(mk(0, 1, 1, 32'h07060504, 1, 1, 8'h03, 1, 1));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 1, 8'h04, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 1, 8'h05, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 1, 8'h06, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 1, 8'h07, 1, 1));
        // backpressure 1,0,0,1,1,0,1 with a competing word offered throughout
        vecs.push_back(mk(0, 1, 1, 32'hDDCCBBAA, 1, 0, 8'h00, 0, 1));
        vecs.push_back(mk(0, 1, 1, 32'h11111111, 1, 1, 8'hAA, 0, 0));
        vecs.push_back(mk(0, 1, 1, 32'h11111111, 0, 1, 8'hBB, 0, 0));
        vecs.push_back(mk(0, 1, 1, 32'h11111111, 0, 1, 8'hBB, 0, 0));
        vecs.push_back(mk(0, 1, 1, 32'h11111111, 1, 1, 8'hBB, 0, 0));
        vecs.push_back(mk(0, 1, 1, 32'h11111111, 1, 1, 8'hCC, 0, 0));
        vecs.push_back(mk(0, 1, 1, 32'h11111111, 0, 1, 8'hDD, 1, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 1, 8'hDD, 1, 1));
        // reset mid-word
        vecs.push_back(mk(0, 1, 1, 32'hDDCCBBAA, 1, 0, 8'h00, 0, 1));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 1, 8'hAA, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 1, 8'hBB, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        1, 0, 8'h00, 0, 1));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 0, 8'h00, 0, 1));
        vecs.push_back(mk(0, 1, 1, 32'h44332211, 1, 0, 8'h00, 0, 1));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 1, 8'h11, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 1, 8'h22, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 1, 8'h33, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 1, 8'h44, 1, 1));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 0, 8'h00, 0, 1));

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            rst          = vecs[i].rst;
            a_in.valid   = vecs[i].iv;
            a_in.payload = vecs[i].id;
            a_out.ready  = vecs[i].ordy;
            #3;
            if (vecs[i].chk) begin
                chk($sformatf("v%0d valid", i), 32'(a_out.valid), 32'(vecs[i].ov));
                chk($sformatf("v%0d last", i), 32'(a_last), 32'(vecs[i].last));
                chk($sformatf("v%0d in_ready", i), 32'(a_in.ready), 32'(vecs[i].irdy));
                if (vecs[i].ov)
                    chk($sformatf("v%0d payload", i), 32'(a_out.payload), 32'(vecs[i].od));
            end
        end

        // MSB-first order and COUNT=1 pass-through, run side by side
        @(posedge clk); #1;
        b_in.valid = 1'b1; b_in.payload = 32'hDDCCBBAA;
        c_in.valid = 1'b1; c_in.payload = 16'h1234;
        #3;
        chk("b idle valid", 32'(b_out.valid), 32'd0);
        chk("b idle in_ready", 32'(b_in.ready), 32'd1);
        chk("c idle valid", 32'(c_out.valid), 32'd0);
        chk("c idle in_ready", 32'(c_in.ready), 32'd1);

        @(posedge clk); #1;
        b_in.valid = 1'b0;
        c_in.payload = 16'h5678;
        #3;
        chk("b beat0", 32'(b_out.payload), 32'hDD);
        chk("b beat0 last", 32'(b_last), 32'd0);
        chk("b beat0 in_ready", 32'(b_in.ready), 32'd0);
        chk("c w0 valid", 32'(c_out.valid), 32'd1);
        chk("c w0 payload", 32'(c_out.payload), 32'h1234);
        chk("c w0 last", 32'(c_last), 32'd1);
        chk("c w0 in_ready", 32'(c_in.ready), 32'd1);

        @(posedge clk); #1;
        c_in.valid = 1'b0;
        #3;
        chk("b beat1", 32'(b_out.payload), 32'hCC);
        chk("c w1 valid", 32'(c_out.valid), 32'd1);
        chk("c w1 payload", 32'(c_out.payload), 32'h5678);
        chk("c w1 last", 32'(c_last), 32'd1);

        @(posedge clk); #4;
        chk("b beat2", 32'(b_out.payload), 32'hBB);
        chk("b beat2 last", 32'(b_last), 32'd0);
        chk("c drained valid", 32'(c_out.valid), 32'd0);
        chk("c drained last", 32'(c_last), 32'd0);

        @(posedge clk); #4;
        chk("b beat3", 32'(b_out.payload), 32'hAA);
        chk("b beat3 last", 32'(b_last), 32'd1);
        chk("b beat3 in_ready", 32'(b_in.ready), 32'd1);

        @(posedge clk); #4;
        chk("b drained valid", 32'(b_out.valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
